hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning forwarded data width.
REQ-002 SHALL provide parameter ADDR_W, default 5, meaning register address width.
REQ-003 SHALL provide parameter MEM_LOAD_STALL, default 0; when 1, load data is unavailable in MEM and loads in MEM also cause a stall.
REQ-004 SHALL provide parameter CNT_W, default 32, meaning stall counter width.
REQ-005 SHALL use one clock and a synchronous active-low reset: clk in 1, rising-edge clock; resetn in 1, synchronous active-low reset.
REQ-006 SHALL have the following DE-stage inputs:
- de_valid in 1: DE holds a valid instruction.
- de_rs_addr, de_rt_addr in ADDR_W: source register addresses.
- de_reg_en in 1, de_waddr in ADDR_W: DE instruction's destination.
- reg_rs_data, reg_rt_data in DATA_W: regfile read data.
- long_issue in 1: DE instruction is a long-latency op (divider).
REQ-007 SHALL have the following EXE-stage inputs: exe_reg_en 1, exe_reg_waddr ADDR_W, exe_reg_wdata DATA_W, exe_mem_read 1, exe_busy 1.
REQ-008 SHALL have the following MEM-stage inputs: mem_reg_en 1, mem_reg_waddr ADDR_W, mem_reg_wdata DATA_W, mem_mem_read 1.
REQ-009 SHALL have the following WB-stage inputs: wb_reg_en 1, wb_reg_waddr ADDR_W, wb_reg_wdata DATA_W.
REQ-010 SHALL have the following long-unit inputs: long_wb_en in 1, long_wb_addr in ADDR_W (long result written back this cycle).
REQ-011 SHALL have input stall_cnt_clr, 1 bit, which clears the stall counter.
REQ-012 SHALL have the following outputs:
- de_rs_data, de_rt_data out DATA_W: resolved operands.
- stall out 1: stall to all stages.
- long_busy out 1: a long op is pending.
- stall_cnt out CNT_W: count of stalled cycles.

Function
REQ-013 SHALL resolve each operand combinationally with priority EXE > MEM > WB > regfile; a source matches a stage when that stage's reg_en=1, waddr!=0 and waddr equals the source address.
REQ-014 SHALL never forward and never stall on address 0; operand for address 0 = reg_*_data.
REQ-015 SHALL assert the load-use stall when de_valid & exe_mem_read & exe_reg_en & exe_reg_waddr!=0 & (rs or rt matches exe_reg_waddr).
REQ-016 SHALL, when MEM_LOAD_STALL=1, also stall when de_valid & mem_mem_read & mem_reg_en & mem_reg_waddr!=0 & (rs or rt matches); when MEM_LOAD_STALL=0, this term is 0.
REQ-017 SHALL hold scoreboard state pend_v (1 bit) and pend_addr (ADDR_W); long_busy = pend_v.
REQ-018 SHALL assert the RAW/WAW stall when de_valid & pend_v & (rs==pend_addr | rt==pend_addr | (de_reg_en & de_waddr==pend_addr)) with pend_addr!=0.
REQ-019 SHALL assert the structural stall when de_valid & long_issue & pend_v & ~(long_wb_en & long_wb_addr==pend_addr).
REQ-020 SHALL compute stall = OR of REQ-015, 016, 018, 019 and exe_busy; exe_busy stalls regardless of de_valid.
REQ-021 SHALL update the scoreboard on each rising edge in this priority:
- (a) de_valid & long_issue & ~stall & de_reg_en & de_waddr!=0: pend_v<=1, pend_addr<=de_waddr.
- (b) else if long_wb_en & long_wb_addr==pend_addr: pend_v<=0.
- (c) else: hold.
REQ-022 SHALL keep the stall asserted in the long_wb_en cycle; the dependent instruction is released the next cycle and reads the value from the regfile.
REQ-023 SHALL let a simultaneous long writeback and a new long issue (REQ-019 exemption) load the new entry per REQ-021(a).
REQ-024 SHALL ignore long_wb_en with a non-matching address or with pend_v=0.
REQ-025 SHALL update stall_cnt each edge as follows:
- stall_cnt_clr: stall_cnt<=0.
- else if stall: stall_cnt increments by 1, saturating at all-ones.
- clear has priority over increment.
REQ-026 SHALL generate forwarding paths and stall combinationally with zero latency; scoreboard and counter effects appear one cycle later.

Reset
REQ-027 SHALL, on a rising edge with resetn=0, set pend_v=0, pend_addr=0 and stall_cnt=0, overriding all other updates, including a mid-pending long op.
REQ-028 SHALL, during reset, keep combinational outputs driven from inputs, with long_busy=0 and no scoreboard-induced stall.

Verification
REQ-029 SHALL verify EXE-over-MEM priority: exe and mem both write r5 (exe=0x11, mem=0x22), de_rs=5 -> de_rs_data=0x11, stall=0.
REQ-030 SHALL verify the load-use stall: exe_mem_read=1 to r7, de_rt=7 -> stall=1, stall_cnt +1 per cycle; with MEM_LOAD_STALL=1, a load in MEM to r7 -> stall=1; with MEM_LOAD_STALL=0 -> de_rt_data=mem_reg_wdata, stall=0.
REQ-031 SHALL verify the long op lifecycle: issue long to r9; next cycle long_busy=1; an instruction reading r9 stalls; long_wb_en with addr 9 -> stall still 1 that cycle; next cycle long_busy=0, stall=0.
REQ-032 SHALL verify the structural hazard: pending r9, second long_issue to r10 -> stall=1; same cycle with long_wb_en/addr 9 -> stall=0, pend_addr=10 next cycle.
REQ-033 SHALL verify r0 handling: exe writes r0 with exe_mem_read=1, de_rs=0 -> stall=0, de_rs_data=reg_rs_data; long_issue with de_waddr=0 -> long_busy stays 0.
REQ-034 SHALL verify reset and saturation: resetn=0 while pending -> long_busy=0, stall_cnt=0 next cycle; CNT_W=4 with 20 stalled cycles -> stall_cnt=15; stall_cnt_clr with stall=1 -> 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Operand forwarding, load-use/long-op hazard detection and stall accounting for the DE stage.
// Forwarding and stall are combinational; scoreboard and stall counter update on the next edge.
module hazard_scoreboard #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int MEM_LOAD_STALL = 0,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              de_valid,
    input  logic [ADDR_W-1:0] de_rs_addr,
    input  logic [ADDR_W-1:0] de_rt_addr,
    input  logic              de_reg_en,
    input  logic [ADDR_W-1:0] de_waddr,
    input  logic [DATA_W-1:0] reg_rs_data,
    input  logic [DATA_W-1:0] reg_rt_data,
    input  logic              long_issue,
    input  logic              exe_reg_en,
    input  logic [ADDR_W-1:0] exe_reg_waddr,
    input  logic [DATA_W-1:0] exe_reg_wdata,
    input  logic              exe_mem_read,
    input  logic              exe_busy,
    input  logic              mem_reg_en,
    input  logic [ADDR_W-1:0] mem_reg_waddr,
    input  logic [DATA_W-1:0] mem_reg_wdata,
    input  logic              mem_mem_read,
    input  logic              wb_reg_en,
    input  logic [ADDR_W-1:0] wb_reg_waddr,
    input  logic [DATA_W-1:0] wb_reg_wdata,
    input  logic              long_wb_en,
    input  logic [ADDR_W-1:0] long_wb_addr,
    input  logic              stall_cnt_clr,
    output logic [DATA_W-1:0] de_rs_data,
    output logic [DATA_W-1:0] de_rt_data,
    output logic              stall,
    output logic              long_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              pend_v_q, pend_v_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic pend_act, long_wb_hit, load_use, mem_load, raw_waw, struct_haz, long_load;

    function automatic logic hit(input logic en, input logic [ADDR_W-1:0] waddr,
                                 input logic [ADDR_W-1:0] src);
        return en && (waddr != '0) && (waddr == src);
    endfunction

    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] src,
                                              input logic [DATA_W-1:0] rf);
        if (hit(exe_reg_en, exe_reg_waddr, src))     return exe_reg_wdata;
        else if (hit(mem_reg_en, mem_reg_waddr, src)) return mem_reg_wdata;
        else if (hit(wb_reg_en, wb_reg_waddr, src))   return wb_reg_wdata;
        else                                          return rf;
    endfunction

    assign de_rs_data = fwd(de_rs_addr, reg_rs_data);
    assign de_rt_data = fwd(de_rt_addr, reg_rt_data);

    // Scoreboard is masked while reset is held so it cannot inject a stall.
    assign pend_act    = pend_v_q & resetn;
    assign long_wb_hit = long_wb_en & (long_wb_addr == pend_addr_q);

    assign load_use = de_valid & exe_mem_read &
                      (hit(exe_reg_en, exe_reg_waddr, de_rs_addr) |
                       hit(exe_reg_en, exe_reg_waddr, de_rt_addr));
    assign mem_load = (MEM_LOAD_STALL != 0) & de_valid & mem_mem_read &
                      (hit(mem_reg_en, mem_reg_waddr, de_rs_addr) |
                       hit(mem_reg_en, mem_reg_waddr, de_rt_addr));
    assign raw_waw  = de_valid & pend_act & (pend_addr_q != '0) &
                      ((de_rs_addr == pend_addr_q) | (de_rt_addr == pend_addr_q) |
                       (de_reg_en & (de_waddr == pend_addr_q)));
    assign struct_haz = de_valid & long_issue & pend_act & ~long_wb_hit;

    assign stall     = load_use | mem_load | raw_waw | struct_haz | exe_busy;
    assign long_busy = pend_act;
    assign stall_cnt = stall_cnt_q;

    assign long_load = de_valid & long_issue & ~stall & de_reg_en & (de_waddr != '0);

    always_comb begin
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        stall_cnt_d = stall_cnt_q;
        if (long_load) begin
            pend_v_d    = 1'b1;
            pend_addr_d = de_waddr;
        end else if (long_wb_hit) begin
            pend_v_d    = 1'b0;
        end
        if (stall_cnt_clr)
            stall_cnt_d = '0;
        else if (stall && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: vector table, hand-written corner sequences, then
// random traffic against a behavioural model; dut1 uses MEM_LOAD_STALL=1 and a 4-bit counter.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        resetn;
    logic        de_valid, de_reg_en, long_issue;
    logic [4:0]  de_rs_addr, de_rt_addr, de_waddr;
    logic [31:0] reg_rs_data, reg_rt_data;
    logic        exe_reg_en, exe_mem_read, exe_busy;
    logic [4:0]  exe_reg_waddr;
    logic [31:0] exe_reg_wdata;
    logic        mem_reg_en, mem_mem_read;
    logic [4:0]  mem_reg_waddr;
    logic [31:0] mem_reg_wdata;
    logic        wb_reg_en;
    logic [4:0]  wb_reg_waddr;
    logic [31:0] wb_reg_wdata;
    logic        long_wb_en;
    logic [4:0]  long_wb_addr;
    logic        stall_cnt_clr;

    logic [31:0] rs0, rt0, cnt0, rs1, rt1;
    logic        stall0, busy0, stall1, busy1;
    logic [3:0]  cnt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut0 (
        .clk(clk), .resetn(resetn), .de_valid(de_valid), .de_rs_addr(de_rs_addr),
        .de_rt_addr(de_rt_addr), .de_reg_en(de_reg_en), .de_waddr(de_waddr),
        .reg_rs_data(reg_rs_data), .reg_rt_data(reg_rt_data), .long_issue(long_issue),
        .exe_reg_en(exe_reg_en), .exe_reg_waddr(exe_reg_waddr), .exe_reg_wdata(exe_reg_wdata),
        .exe_mem_read(exe_mem_read), .exe_busy(exe_busy), .mem_reg_en(mem_reg_en),
        .mem_reg_waddr(mem_reg_waddr), .mem_reg_wdata(mem_reg_wdata), .mem_mem_read(mem_mem_read),
        .wb_reg_en(wb_reg_en), .wb_reg_waddr(wb_reg_waddr), .wb_reg_wdata(wb_reg_wdata),
        .long_wb_en(long_wb_en), .long_wb_addr(long_wb_addr), .stall_cnt_clr(stall_cnt_clr),
        .de_rs_data(rs0), .de_rt_data(rt0), .stall(stall0), .long_busy(busy0), .stall_cnt(cnt0)
    );

    hazard_scoreboard #(.MEM_LOAD_STALL(1), .CNT_W(4)) dut1 (
        .clk(clk), .resetn(resetn), .de_valid(de_valid), .de_rs_addr(de_rs_addr),
        .de_rt_addr(de_rt_addr), .de_reg_en(de_reg_en), .de_waddr(de_waddr),
        .reg_rs_data(reg_rs_data), .reg_rt_data(reg_rt_data), .long_issue(long_issue),
        .exe_reg_en(exe_reg_en), .exe_reg_waddr(exe_reg_waddr), .exe_reg_wdata(exe_reg_wdata),
        .exe_mem_read(exe_mem_read), .exe_busy(exe_busy), .mem_reg_en(mem_reg_en),
        .mem_reg_waddr(mem_reg_waddr), .mem_reg_wdata(mem_reg_wdata), .mem_mem_read(mem_mem_read),
        .wb_reg_en(wb_reg_en), .wb_reg_waddr(wb_reg_waddr), .wb_reg_wdata(wb_reg_wdata),
        .long_wb_en(long_wb_en), .long_wb_addr(long_wb_addr), .stall_cnt_clr(stall_cnt_clr),
        .de_rs_data(rs1), .de_rt_data(rt1), .stall(stall1), .long_busy(busy1), .stall_cnt(cnt1)
    );

    typedef struct {
        logic [4:0]  rs, rt;
        logic        exe_en;
        logic [4:0]  exe_a;
        logic        exe_rd;
        logic        mem_en;
        logic [4:0]  mem_a;
        logic        mem_rd;
        logic        wb_en;
        logic [4:0]  wb_a;
        logic [31:0] e_rs, e_rt;
        logic        e_st0, e_st1;
    } vec_t;

    vec_t vecs[8];

    // Behavioural model state, index 0 = default DUT, 1 = MEM_LOAD_STALL/CNT_W=4 DUT
    logic        m_pv[2];
    logic [4:0]  m_pa[2];
    logic [31:0] m_cnt[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        resetn = 1'b1; de_valid = 1'b0; de_reg_en = 1'b0; long_issue = 1'b0;
        de_rs_addr = 5'd0; de_rt_addr = 5'd0; de_waddr = 5'd0;
        reg_rs_data = 32'hA0; reg_rt_data = 32'hB0;
        exe_reg_en = 1'b0; exe_reg_waddr = 5'd0; exe_reg_wdata = 32'h11;
        exe_mem_read = 1'b0; exe_busy = 1'b0;
        mem_reg_en = 1'b0; mem_reg_waddr = 5'd0; mem_reg_wdata = 32'h22; mem_mem_read = 1'b0;
        wb_reg_en = 1'b0; wb_reg_waddr = 5'd0; wb_reg_wdata = 32'h33;
        long_wb_en = 1'b0; long_wb_addr = 5'd0; stall_cnt_clr = 1'b0;
    endtask

    task automatic issue_long(input logic [4:0] dst);
        set_idle();
        de_valid = 1'b1; long_issue = 1'b1; de_reg_en = 1'b1; de_waddr = dst;
        de_rs_addr = 5'd1; de_rt_addr = 5'd2;
    endtask

    function automatic logic [31:0] model_fwd(input logic [4:0] src, input logic [31:0] rf);
        logic        en[3];
        logic [4:0]  a[3];
        logic [31:0] d[3];
        en = '{exe_reg_en, mem_reg_en, wb_reg_en};
        a  = '{exe_reg_waddr, mem_reg_waddr, wb_reg_waddr};
        d  = '{exe_reg_wdata, mem_reg_wdata, wb_reg_wdata};
        if (src == 5'd0) return rf;
        for (int i = 0; i < 3; i++)
            if (en[i] && a[i] == src) return d[i];
        return rf;
    endfunction

    function automatic logic model_stall(input int k);
        logic [4:0] srcs[2];
        logic pend, hz;
        pend = m_pv[k] && resetn;
        hz = 1'b0;
        srcs = '{de_rs_addr, de_rt_addr};
        foreach (srcs[j]) begin
            if (srcs[j] != 5'd0) begin
                if (exe_reg_en && exe_mem_read && exe_reg_waddr == srcs[j]) hz = 1'b1;
                if (k == 1 && mem_reg_en && mem_mem_read && mem_reg_waddr == srcs[j]) hz = 1'b1;
                if (pend && m_pa[k] == srcs[j]) hz = 1'b1;
            end
        end
        if (pend && m_pa[k] != 5'd0 && de_reg_en && de_waddr == m_pa[k]) hz = 1'b1;
        if (pend && long_issue && !(long_wb_en && long_wb_addr == m_pa[k])) hz = 1'b1;
        return exe_busy || (de_valid && hz);
    endfunction

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    logic [31:0] cmax[2];
    logic        st_exp[2];

    initial begin
        set_idle();
        resetn = 1'b0;
        tick();
        tick();
        chk("reset_busy0", 32'(busy0), 32'd0);
        chk("reset_busy1", 32'(busy1), 32'd0);
        chk("reset_cnt0", cnt0, 32'd0);
        chk("reset_cnt1", 32'(cnt1), 32'd0);
        resetn = 1'b1;

        // ---------------- forwarding / load-use table ----------------
        vecs[0] = '{5'd5, 5'd6, 1'b1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 32'h11, 32'hB0, 1'b0, 1'b0};
        vecs[1] = '{5'd5, 5'd6, 1'b0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 5'd6, 32'h22, 32'h33, 1'b0, 1'b0};
        vecs[2] = '{5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'hA0, 32'h11, 1'b1, 1'b1};
        vecs[3] = '{5'd1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 32'hA0, 32'h22, 1'b0, 1'b1};
        vecs[4] = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 32'hA0, 32'hB0, 1'b0, 1'b0};
        vecs[5] = '{5'd3, 5'd3, 1'b1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 5'd3, 32'h33, 32'h33, 1'b0, 1'b0};
        vecs[6] = '{5'd4, 5'd2, 1'b1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 5'd4, 32'h22, 32'h11, 1'b1, 1'b1};
        vecs[7] = '{5'd6, 5'd9, 1'b1, 5'd9, 1'b0, 1'b1, 5'd6, 1'b1, 1'b1, 5'd9, 32'h22, 32'h11, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            set_idle();
            de_valid = 1'b1; de_rs_addr = vecs[i].rs; de_rt_addr = vecs[i].rt;
            exe_reg_en = vecs[i].exe_en; exe_reg_waddr = vecs[i].exe_a; exe_mem_read = vecs[i].exe_rd;
            mem_reg_en = vecs[i].mem_en; mem_reg_waddr = vecs[i].mem_a; mem_mem_read = vecs[i].mem_rd;
            wb_reg_en = vecs[i].wb_en; wb_reg_waddr = vecs[i].wb_a;
            #1;
            chk($sformatf("vec%0d_rs", i), rs0, vecs[i].e_rs);
            chk($sformatf("vec%0d_rt", i), rt0, vecs[i].e_rt);
            chk($sformatf("vec%0d_rt_d1", i), rt1, vecs[i].e_rt);
            chk($sformatf("vec%0d_stall0", i), 32'(stall0), 32'(vecs[i].e_st0));
            chk($sformatf("vec%0d_stall1", i), 32'(stall1), 32'(vecs[i].e_st1));
            tick();
        end

        // ---------------- load-use stall counting ----------------
        set_idle();
        stall_cnt_clr = 1'b1;
        tick();
        set_idle();
        de_valid = 1'b1; de_rt_addr = 5'd7; exe_reg_en = 1'b1; exe_reg_waddr = 5'd7; exe_mem_read = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("loaduse_cnt0_%0d", i), cnt0, 32'(i));
            chk($sformatf("loaduse_cnt1_%0d", i), 32'(cnt1), 32'(i));
        end

        // ---------------- long op lifecycle ----------------
        issue_long(5'd9);
        #1;
        chk("long_issue_stall", 32'(stall0), 32'd0);
        tick();
        set_idle();
        de_valid = 1'b1; de_rs_addr = 5'd9; de_rt_addr = 5'd1;
        #1;
        chk("long_busy_after_issue", 32'(busy0), 32'd1);
        chk("long_busy_after_issue_d1", 32'(busy1), 32'd1);
        chk("long_raw_stall", 32'(stall0), 32'd1);
        tick();
        long_wb_en = 1'b1; long_wb_addr = 5'd9;
        #1;
        chk("long_wb_cycle_stall", 32'(stall0), 32'd1);
        tick();
        long_wb_en = 1'b0;
        #1;
        chk("long_released_busy", 32'(busy0), 32'd0);
        chk("long_released_stall", 32'(stall0), 32'd0);

        // ---------------- structural hazard ----------------
        issue_long(5'd9);
        tick();
        issue_long(5'd10);
        #1;
        chk("struct_stall", 32'(stall0), 32'd1);
        long_wb_en = 1'b1; long_wb_addr = 5'd9;
        #1;
        chk("struct_wb_exempt", 32'(stall0), 32'd0);
        tick();
        set_idle();
        de_valid = 1'b1; de_rs_addr = 5'd10; de_rt_addr = 5'd1;
        #1;
        chk("struct_new_busy", 32'(busy0), 32'd1);
        chk("struct_new_addr10", 32'(stall0), 32'd1);
        de_rs_addr = 5'd9;
        #1;
        chk("struct_old_addr9", 32'(stall0), 32'd0);
        set_idle();
        long_wb_en = 1'b1; long_wb_addr = 5'd10;
        tick();
        set_idle();
        #1;
        chk("struct_drain", 32'(busy0), 32'd0);

        // ---------------- r0 long issue ----------------
        issue_long(5'd0);
        tick();
        set_idle();
        #1;
        chk("r0_long_busy", 32'(busy0), 32'd0);

        // ---------------- reset while pending ----------------
        issue_long(5'd9);
        tick();
        set_idle();
        #1;
        chk("rst_pending_busy", 32'(busy0), 32'd1);
        resetn = 1'b0;
        de_valid = 1'b1; de_rs_addr = 5'd9;
        #1;
        chk("rst_comb_busy", 32'(busy0), 32'd0);
        chk("rst_comb_stall", 32'(stall0), 32'd0);
        tick();
        resetn = 1'b1;
        de_valid = 1'b0;
        #1;
        chk("rst_after_busy", 32'(busy0), 32'd0);
        chk("rst_after_cnt0", cnt0, 32'd0);
        chk("rst_after_cnt1", 32'(cnt1), 32'd0);

        // ---------------- saturation and clear ----------------
        set_idle();
        exe_busy = 1'b1;
        repeat (20) tick();
        chk("sat_cnt1", 32'(cnt1), 32'd15);
        chk("sat_cnt0", cnt0, 32'd20);
        stall_cnt_clr = 1'b1;
        #1;
        chk("clr_stall_high", 32'(stall0), 32'd1);
        tick();
        chk("clr_cnt0", cnt0, 32'd0);
        chk("clr_cnt1", 32'(cnt1), 32'd0);

        // ---------------- random traffic vs model ----------------
        set_idle();
        resetn = 1'b0;
        tick();
        cmax[0] = 32'hFFFF_FFFF;
        cmax[1] = 32'd15;
        for (int k = 0; k < 2; k++) begin
            m_pv[k] = 1'b0; m_pa[k] = 5'd0; m_cnt[k] = 32'd0;
        end
        for (int n = 0; n < 1500; n++) begin
            resetn        = ($urandom_range(0, 49) != 0);
            de_valid      = ($urandom_range(0, 3) != 0);
            de_rs_addr    = raddr();
            de_rt_addr    = raddr();
            de_reg_en     = 1'($urandom_range(0, 1));
            de_waddr      = raddr();
            long_issue    = ($urandom_range(0, 3) == 0);
            reg_rs_data   = $urandom;
            reg_rt_data   = $urandom;
            exe_reg_en    = 1'($urandom_range(0, 1));
            exe_reg_waddr = raddr();
            exe_reg_wdata = $urandom;
            exe_mem_read  = ($urandom_range(0, 2) == 0);
            exe_busy      = ($urandom_range(0, 9) == 0);
            mem_reg_en    = 1'($urandom_range(0, 1));
            mem_reg_waddr = raddr();
            mem_reg_wdata = $urandom;
            mem_mem_read  = ($urandom_range(0, 2) == 0);
            wb_reg_en     = 1'($urandom_range(0, 1));
            wb_reg_waddr  = raddr();
            wb_reg_wdata  = $urandom;
            long_wb_en    = ($urandom_range(0, 2) == 0);
            long_wb_addr  = $urandom_range(0, 1) ? m_pa[0] : raddr();
            stall_cnt_clr = ($urandom_range(0, 19) == 0);
            #1;
            chk("rnd_rs0", rs0, model_fwd(de_rs_addr, reg_rs_data));
            chk("rnd_rt0", rt0, model_fwd(de_rt_addr, reg_rt_data));
            chk("rnd_rs1", rs1, model_fwd(de_rs_addr, reg_rs_data));
            st_exp[0] = model_stall(0);
            st_exp[1] = model_stall(1);
            chk("rnd_stall0", 32'(stall0), 32'(st_exp[0]));
            chk("rnd_stall1", 32'(stall1), 32'(st_exp[1]));
            chk("rnd_busy0", 32'(busy0), 32'(m_pv[0] && resetn));
            chk("rnd_busy1", 32'(busy1), 32'(m_pv[1] && resetn));
            chk("rnd_cnt0", cnt0, m_cnt[0]);
            chk("rnd_cnt1", 32'(cnt1), m_cnt[1]);
            for (int k = 0; k < 2; k++) begin
                if (!resetn) begin
                    m_pv[k] = 1'b0; m_pa[k] = 5'd0; m_cnt[k] = 32'd0;
                end else begin
                    if (de_valid && long_issue && !st_exp[k] && de_reg_en && de_waddr != 5'd0) begin
                        m_pv[k] = 1'b1; m_pa[k] = de_waddr;
                    end else if (m_pv[k] && long_wb_en && long_wb_addr == m_pa[k]) begin
                        m_pv[k] = 1'b0;
                    end
                    if (stall_cnt_clr) m_cnt[k] = 32'd0;
                    else if (st_exp[k] && m_cnt[k] != cmax[k]) m_cnt[k] = m_cnt[k] + 32'd1;
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
